line_fetch_ctrl: RTL and testbench
==================================

Name: line_fetch_ctrl

Overview:
Responder side of the CPU sequencer handshake. It decodes the SequencerState value `q` from params.svh and performs that state's actions:
- fetches a 3-byte instruction line from program memory;
- times single- and multi-cycle operations;
- raises `nxt_line`, `finish` and `err` back to the sequencer.

It sits between the sequencer, program memory and the datapath, and owns the program counter.

Parameters:
- ADDR_W, 8, program memory address width.
- DATA_W, 8, memory byte width; the instruction is 3 bytes wide.
- LINES, 85, number of instruction lines. LINES*3 <= 2**ADDR_W is required.
- MUL_CYC, 4, SCALC cycles for MUL (>=1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- q  in  SequencerState  current sequencer state.
- mem_rd  out  1  memory read strobe. Data returns on `mem_rdata` the next cycle.
- mem_addr  out  ADDR_W  memory byte address.
- mem_rdata  in  DATA_W  memory read data.
- opcode  out  DATA_W  latched byte 0.
- opa  out  DATA_W  latched byte 1.
- opb  out  DATA_W  latched byte 2.
- pc  out  $clog2(LINES)  current line index.
- wr_en  out  1  datapath writeback strobe.
- nxt_line  out  1  to sequencer: operation complete.
- finish  out  1  to sequencer: HALT reached.
- err  out  1  to sequencer: fault.

Behaviour:
- Reset: sync on the `clk` edge with `rstn`=0. pc, opcode, opa, opb, calc_cnt and err_flag all go to 0. Reset overrides every other update, including mid-MUL.
- Line base address is pc*3, truncated to ADDR_W. `mem_rd` and `mem_addr` are combinational from `q` and pc.
- Per sequencer state:
  - SREAD: mem_rd=1, mem_addr=base.
  - SLOAD1: latch opcode<=mem_rdata; mem_rd=1, mem_addr=base+1.
  - SLOAD2: latch opa<=mem_rdata; mem_rd=1, mem_addr=base+2.
  - SLOAD3: latch opb<=mem_rdata; mem_rd=0; calc_cnt<=0.
  - SCALC: calc_cnt increments each cycle, saturating at MUL_CYC-1.
  - SWRITE: wr_en=1 for ALU and MUL classes, 0 for NOP.
  - SNXT: pc<=pc+1 at the clock edge, unless pc==LINES-1 (see fault below).
  - SRST, SFINISH, SERR and all other states: mem_rd=0, wr_en=0, registers hold.
- Decode on opcode[7:4]:
  - 0x0 NOP, latency 1.
  - 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR, 0x5 XOR: ALU class, latency 1.
  - 0x8 MUL, latency MUL_CYC.
  - 0xF HALT.
  - All other values illegal.
- nxt_line = (q==SCALC) & legal & !HALT & (calc_cnt==latency-1). This is combinational, so the sequencer leaves SCALC on the same edge.
  - Latency-1 ops: SCALC lasts exactly 1 cycle.
  - MUL: SCALC lasts exactly MUL_CYC cycles.
- finish = (q==SCALC) & HALT. It is asserted in the first SCALC cycle; nxt_line stays 0.
- Faults: err_comb = (q==SCALC & illegal) | (q==SNXT & pc==LINES-1).
  - err_flag <= 1 when err_comb=1; sticky until reset.
  - err = err_comb | err_flag.
  - On a fault, pc does not wrap: it holds at LINES-1.
  - Under a fault, nxt_line and finish are 0.
- Simultaneous events: err has priority over finish and nxt_line.
- `q`=SRST does not clear pc or err_flag; only `rstn` does.
- `mem_rdata` is sampled only in the SLOAD1/2/3 cycles; it is ignored at all other times.

Test Plan:
1. Fetch timing: mem holds line0 = 0x12,0x34,0x56. Drive SREAD→SLOAD1→SLOAD2→SLOAD3 →
   - mem_addr = 0,1,2, then mem_rd=0;
   - afterwards opcode=0x12, opa=0x34, opb=0x56.
2. ADD single-cycle: line0 = 0x10,0x03,0x04; hold q=SCALC →
   - nxt_line=1 in the first SCALC cycle;
   - SWRITE gives wr_en=1;
   - SNXT then gives pc=1, and the next SREAD has mem_addr=3.
3. MUL multicycle (MUL_CYC=4): opcode 0x80, q held at SCALC →
   - nxt_line=0 for 3 cycles, =1 on the 4th;
   - stays 1 while q remains in SCALC.
4. HALT / illegal: opcode 0xF0 → finish=1, nxt_line=0, err=0. Opcode 0x90 → err=1 in SCALC; err stays 1 after q moves to SERR until rstn=0.
5. PC end: pc=LINES-1=84, q=SNXT → err=1 and pc stays 84. Then rstn=0 for one edge → pc=0, err=0.
6. Reset mid-MUL: rstn=0 at the 2nd SCALC cycle of a MUL → after the edge, calc_cnt=0, opcode=0, pc=0 and all outputs are 0 with q=SRST.

Source files
------------

// File: rtl/line_fetch_ctrl.sv
// Responder side of the sequencer handshake: fetches the 3-byte instruction
// line, times SCALC, owns the program counter and reports done/halt/fault.
module line_fetch_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LINES   = 85,
  parameter int unsigned MUL_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [3:0]                 q,
  output logic                       mem_rd,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [DATA_W-1:0]          opcode,
  output logic [DATA_W-1:0]          opa,
  output logic [DATA_W-1:0]          opb,
  output logic [$clog2(LINES)-1:0]   pc,
  output logic                       wr_en,
  output logic                       nxt_line,
  output logic                       finish,
  output logic                       err
);

  // SequencerState encoding
  localparam logic [3:0] SRST    = 4'd0;
  localparam logic [3:0] SREAD   = 4'd1;
  localparam logic [3:0] SLOAD1  = 4'd2;
  localparam logic [3:0] SLOAD2  = 4'd3;
  localparam logic [3:0] SLOAD3  = 4'd4;
  localparam logic [3:0] SCALC   = 4'd5;
  localparam logic [3:0] SWRITE  = 4'd6;
  localparam logic [3:0] SNXT    = 4'd7;
  localparam logic [3:0] SFINISH = 4'd8;
  localparam logic [3:0] SERR    = 4'd9;

  localparam int unsigned PcW   = $clog2(LINES);
  localparam int unsigned BaseW = PcW + 2;
  localparam int unsigned CntW  = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MUL_CYC - 1);
  localparam logic [PcW-1:0]  PcLast  = PcW'(LINES - 1);

  logic [PcW-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [CntW-1:0]   calc_cnt_q, calc_cnt_d;
  logic              err_flag_q, err_flag_d;

  logic [BaseW-1:0]  base_w;
  logic [ADDR_W-1:0] base;
  logic [3:0]        op_hi;
  logic              is_nop, is_alu, is_mul, is_halt, legal;
  logic [CntW-1:0]   lat_last;
  logic              pc_at_end;
  logic              err_comb;

  // Instruction decode and line base address
  always_comb begin
    base_w    = BaseW'(pc_q) * BaseW'(3);
    base      = ADDR_W'(base_w);
    op_hi     = opcode_q[7:4];
    is_nop    = (op_hi == 4'h0);
    is_alu    = (op_hi >= 4'h1) && (op_hi <= 4'h5);
    is_mul    = (op_hi == 4'h8);
    is_halt   = (op_hi == 4'hF);
    legal     = is_nop | is_alu | is_mul | is_halt;
    lat_last  = is_mul ? CntMax : '0;
    pc_at_end = (pc_q == PcLast);
    err_comb  = ((q == SCALC) && !legal) || ((q == SNXT) && pc_at_end);
  end

  // Handshake outputs; a fault masks completion and halt
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = base;
    case (q)
      SREAD:  mem_rd = 1'b1;
      SLOAD1: begin
        mem_rd   = 1'b1;
        mem_addr = base + ADDR_W'(1);
      end
      SLOAD2: begin
        mem_rd   = 1'b1;
        mem_addr = base + ADDR_W'(2);
      end
      default: ;
    endcase
    err      = err_comb | err_flag_q;
    wr_en    = (q == SWRITE) && (is_alu || is_mul);
    nxt_line = (q == SCALC) && legal && !is_halt && (calc_cnt_q == lat_last) && !err;
    finish   = (q == SCALC) && is_halt && !err;
    pc       = pc_q;
    opcode   = opcode_q;
    opa      = opa_q;
    opb      = opb_q;
  end

  // Next-state for line latches, op timer, pc and sticky fault
  always_comb begin
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    calc_cnt_d = calc_cnt_q;
    err_flag_d = err_flag_q | err_comb;
    case (q)
      SLOAD1: opcode_d = mem_rdata;
      SLOAD2: opa_d    = mem_rdata;
      SLOAD3: begin
        opb_d      = mem_rdata;
        calc_cnt_d = '0;
      end
      SCALC: begin
        if (calc_cnt_q != CntMax) calc_cnt_d = calc_cnt_q + CntW'(1);
      end
      SNXT: begin
        // The last line has no successor: hold pc and let err_comb report it
        if (!pc_at_end) pc_d = pc_q + PcW'(1);
      end
      default: ;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q       <= '0;
      opcode_q   <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      calc_cnt_q <= '0;
      err_flag_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      calc_cnt_q <= calc_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Directed bench for line_fetch_ctrl with a byte-wide program memory model.
module tb_line_fetch_ctrl;

  localparam logic [3:0] SRST    = 4'd0;
  localparam logic [3:0] SREAD   = 4'd1;
  localparam logic [3:0] SLOAD1  = 4'd2;
  localparam logic [3:0] SLOAD2  = 4'd3;
  localparam logic [3:0] SLOAD3  = 4'd4;
  localparam logic [3:0] SCALC   = 4'd5;
  localparam logic [3:0] SWRITE  = 4'd6;
  localparam logic [3:0] SNXT    = 4'd7;
  localparam logic [3:0] SERR    = 4'd9;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] q;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] opcode, opa, opb;
  logic [6:0] pc;
  logic       wr_en, nxt_line, finish, err;

  logic [7:0] mem [256];
  int total = 0;
  int bad   = 0;

  line_fetch_ctrl dut (
    .clk      (clk),
    .rstn     (rstn),
    .q        (q),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .opcode   (opcode),
    .opa      (opa),
    .opb      (opb),
    .pc       (pc),
    .wr_en    (wr_en),
    .nxt_line (nxt_line),
    .finish   (finish),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after the strobe; junk otherwise
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 8'hA5;

  task automatic set_q(input logic [3:0] s);
    @(negedge clk);
    q = s;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    q    = SRST;
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic fetch_line();
    set_q(SREAD);
    set_q(SLOAD1);
    set_q(SLOAD2);
    set_q(SLOAD3);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 7'd0) begin bad++; $display("FAIL reset_pc got=%0h want=0", pc); end
    total++; if ({opcode, opa, opb} !== 24'h0) begin
      bad++; $display("FAIL reset_ops got=%0h want=0", {opcode, opa, opb}); end
    total++; if ({mem_rd, wr_en, nxt_line, finish, err} !== 5'b0) begin
      bad++; $display("FAIL reset_outs got=%b want=00000", {mem_rd, wr_en, nxt_line, finish, err});
    end
    total++; if (mem_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0h want=0", mem_addr); end
  endtask

  task automatic test_fetch();
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    set_q(SREAD);
    total++; if ({mem_rd, mem_addr} !== {1'b1, 8'd0}) begin
      bad++; $display("FAIL fetch_rd0 got=%0h want=100", {mem_rd, mem_addr}); end
    set_q(SLOAD1);
    total++; if ({mem_rd, mem_addr} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL fetch_rd1 got=%0h want=101", {mem_rd, mem_addr}); end
    set_q(SLOAD2);
    total++; if ({mem_rd, mem_addr} !== {1'b1, 8'd2}) begin
      bad++; $display("FAIL fetch_rd2 got=%0h want=102", {mem_rd, mem_addr}); end
    total++; if (opcode !== 8'h12) begin bad++; $display("FAIL fetch_op got=%0h want=12", opcode); end
    set_q(SLOAD3);
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL fetch_rd3 got=%b want=0", mem_rd); end
    total++; if (opa !== 8'h34) begin bad++; $display("FAIL fetch_opa got=%0h want=34", opa); end
    set_q(SRST);
    set_q(SRST);
    total++; if ({opcode, opa, opb} !== 24'h123456) begin
      bad++; $display("FAIL fetch_line got=%0h want=123456", {opcode, opa, opb}); end
  endtask

  task automatic test_add();
    do_reset();
    mem[0] = 8'h10; mem[1] = 8'h03; mem[2] = 8'h04;
    fetch_line();
    set_q(SCALC);
    total++; if ({nxt_line, finish, err} !== 3'b100) begin
      bad++; $display("FAIL add_calc got=%b want=100", {nxt_line, finish, err}); end
    set_q(SWRITE);
    total++; if ({wr_en, nxt_line} !== 2'b10) begin
      bad++; $display("FAIL add_wr got=%b want=10", {wr_en, nxt_line}); end
    set_q(SNXT);
    total++; if ({pc, err} !== {7'd0, 1'b0}) begin
      bad++; $display("FAIL add_snxt got=%0h want=0", {pc, err}); end
    set_q(SREAD);
    total++; if (pc !== 7'd1) begin bad++; $display("FAIL add_pc got=%0h want=1", pc); end
    total++; if (mem_addr !== 8'd3) begin bad++; $display("FAIL add_addr got=%0h want=3", mem_addr); end
  endtask

  // Continues on line 1 (pc=1) left by test_add
  task automatic test_mul();
    logic [5:0] got;
    mem[3] = 8'h80; mem[4] = 8'h07; mem[5] = 8'h09;
    fetch_line();
    total++; if (opcode !== 8'h80) begin bad++; $display("FAIL mul_op got=%0h want=80", opcode); end
    for (int i = 0; i < 6; i++) begin
      set_q(SCALC);
      got[i] = nxt_line;
    end
    total++; if (got !== 6'b111000) begin
      bad++; $display("FAIL mul_timing got=%b want=111000", got); end
    set_q(SWRITE);
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL mul_wr got=%b want=1", wr_en); end
  endtask

  task automatic test_halt_illegal();
    do_reset();
    mem[0] = 8'hF0;
    fetch_line();
    set_q(SCALC);
    total++; if ({finish, nxt_line, err} !== 3'b100) begin
      bad++; $display("FAIL halt_calc got=%b want=100", {finish, nxt_line, err}); end
    set_q(SWRITE);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL halt_wr got=%b want=0", wr_en); end
    do_reset();
    mem[0] = 8'h90;
    fetch_line();
    set_q(SCALC);
    total++; if ({err, finish, nxt_line} !== 3'b100) begin
      bad++; $display("FAIL ill_calc got=%b want=100", {err, finish, nxt_line}); end
    set_q(SERR);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b want=1", err); end
    set_q(SRST);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_srst got=%b want=1", err); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ill_clear got=%b want=0", err); end
    // Upper edge of the ALU range is legal, one above is not
    mem[0] = 8'h50;
    fetch_line();
    set_q(SCALC);
    total++; if ({nxt_line, err} !== 2'b10) begin
      bad++; $display("FAIL xor_calc got=%b want=10", {nxt_line, err}); end
    do_reset();
    mem[0] = 8'h60;
    fetch_line();
    set_q(SCALC);
    total++; if ({nxt_line, err} !== 2'b01) begin
      bad++; $display("FAIL op6_calc got=%b want=01", {nxt_line, err}); end
    do_reset();
  endtask

  task automatic test_pc_end();
    do_reset();
    for (int i = 0; i < 84; i++) set_q(SNXT);
    set_q(SREAD);
    total++; if ({pc, err} !== {7'd84, 1'b0}) begin
      bad++; $display("FAIL end_reach got=%0h want=a8", {pc, err}); end
    total++; if (mem_addr !== 8'd252) begin bad++; $display("FAIL end_addr got=%0d want=252", mem_addr); end
    set_q(SNXT);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL end_err got=%b want=1", err); end
    set_q(SRST);
    total++; if ({pc, err} !== {7'd84, 1'b1}) begin
      bad++; $display("FAIL end_hold got=%0h want=a9", {pc, err}); end
    do_reset();
    total++; if ({pc, err} !== {7'd0, 1'b0}) begin
      bad++; $display("FAIL end_clear got=%0h want=0", {pc, err}); end
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    set_q(SNXT);
    mem[3] = 8'h80; mem[4] = 8'h11; mem[5] = 8'h22;
    fetch_line();
    set_q(SCALC);
    @(negedge clk);
    q    = SCALC;
    rstn = 1'b0;
    @(negedge clk);
    q    = SRST;
    rstn = 1'b1;
    #1;
    total++; if ({pc, opcode, opa, opb} !== 31'h0) begin
      bad++; $display("FAIL rmul_regs got=%0h want=0", {pc, opcode, opa, opb}); end
    total++; if ({mem_rd, mem_addr, wr_en, nxt_line, finish, err} !== 12'h0) begin
      bad++; $display("FAIL rmul_outs got=%0h want=0", {mem_rd, mem_addr, wr_en, nxt_line, finish, err});
    end
    // Cleared counter with opcode 0 (NOP) completes in the first SCALC cycle
    set_q(SCALC);
    total++; if (nxt_line !== 1'b1) begin bad++; $display("FAIL rmul_cnt got=%b want=1", nxt_line); end
    set_q(SWRITE);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL nop_wr got=%b want=0", wr_en); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rstn = 1'b0;
    q    = SRST;
    repeat (2) @(posedge clk);
    test_reset();
    test_fetch();
    test_add();
    test_mul();
    test_halt_illegal();
    test_pc_end();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
